if_fetch_ctrl: RTL and testbench

//  Sequencer for the instruction-fetch stage. Drives the IF PC-select mux, pc_write and pipeline

---
 rtl/if_fetch_ctrl_if.sv | 25 ++
 rtl/if_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Control bundle between the hazard/branch-resolution logic (master) and the
// IF-stage fetch sequencer (slave).
interface if_fetch_ctrl_if;
  logic       redir_valid;
  logic [1:0] redir_sel;
  logic       ld_use_stall;
  logic       mem_busy;
  logic       halt_req;
  logic [1:0] pc_update_mux_signal;
  logic       pc_write;
  logic       freeze;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       halted;

  modport master (
    output redir_valid, redir_sel, ld_use_stall, mem_busy, halt_req,
    input  pc_update_mux_signal, pc_write, freeze, flush_if_id, flush_id_ex, halted
  );

  modport slave (
    input  redir_valid, redir_sel, ld_use_stall, mem_busy, halt_req,
    output pc_update_mux_signal, pc_write, freeze, flush_if_id, flush_id_ex, halted
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: boot, run, memory-wait redirect buffering, halt drain.
// Optional perf counters (stall_cnt/flush_cnt) are built when IF_PERF_CNT_EN is defined.
module if_fetch_ctrl #(
  parameter int BOOT_CYCLES  = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef IF_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  if_fetch_ctrl_if.slave   bus
);

  generate
    if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15 || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 ||
        CNT_W < 1) begin : g_bad_param
      $error("if_fetch_ctrl: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_RUN     = 3'd1,
    S_MEMWAIT = 3'd2,
    S_DRAIN   = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       pend_valid_reg, pend_valid_next;
  logic [1:0] pend_sel_reg, pend_sel_next;

  logic [1:0] sel;
  logic       pc_write, freeze, flush_if_id, flush_id_ex, halted;
  logic       redirect_now;
  logic       run_mode;

  // MEMWAIT with memory ready and nothing buffered behaves exactly like RUN.
  assign run_mode = (state_reg == S_RUN) ||
                    (state_reg == S_MEMWAIT && !bus.mem_busy && !pend_valid_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_BOOT;
      cnt_reg        <= 4'd0;
      pend_valid_reg <= 1'b0;
      pend_sel_reg   <= 2'b00;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_sel_reg   <= pend_sel_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_sel_next   = pend_sel_reg;
    case (state_reg)
      S_BOOT: begin
        if (cnt_reg == BOOT_LAST) begin
          state_next = S_RUN;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      S_MEMWAIT: begin
        if (bus.mem_busy) begin
          // first redirect seen during the stall wins; later ones are wrong-path
          if (bus.redir_valid && !pend_valid_reg) begin
            pend_valid_next = 1'b1;
            pend_sel_next   = bus.redir_sel;
          end
        end else if (pend_valid_reg) begin
          pend_valid_next = 1'b0;
          state_next      = S_RUN;
        end
      end
      S_DRAIN: begin
        if (bus.redir_valid) begin
          state_next = S_RUN;
          cnt_next   = 4'd0;
        end else if (!bus.mem_busy) begin
          if (cnt_reg == DRAIN_LAST) begin
            state_next = S_HALTED;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
      end
      S_RUN, S_HALTED: ;
      default: begin
        state_next      = S_BOOT;
        cnt_next        = 4'd0;
        pend_valid_next = 1'b0;
        pend_sel_next   = 2'b00;
      end
    endcase

    if (run_mode) begin
      if (bus.mem_busy) begin
        state_next = S_MEMWAIT;
        if (bus.redir_valid) begin
          pend_valid_next = 1'b1;
          pend_sel_next   = bus.redir_sel;
        end
      end else if (bus.redir_valid) begin
        state_next = S_RUN;
      end else if (bus.halt_req) begin
        state_next = S_DRAIN;
        cnt_next   = 4'd0;
      end else begin
        state_next = S_RUN;
      end
    end
  end

  always_comb begin
    sel          = 2'b00;
    pc_write     = 1'b1;
    freeze       = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    halted       = 1'b0;
    redirect_now = 1'b0;
    case (state_reg)
      S_MEMWAIT: begin
        if (bus.mem_busy) begin
          pc_write = 1'b0;
          freeze   = 1'b1;
        end else if (pend_valid_reg) begin
          sel          = pend_sel_reg;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          redirect_now = 1'b1;
        end
      end
      S_DRAIN: begin
        pc_write    = 1'b0;
        flush_if_id = 1'b1;
        if (bus.redir_valid) begin
          // an older branch resolved taken: the halt was on the wrong path
          sel          = bus.redir_sel;
          pc_write     = 1'b1;
          flush_id_ex  = 1'b1;
          redirect_now = 1'b1;
        end else if (bus.mem_busy) begin
          freeze = 1'b1;
        end
      end
      S_HALTED: begin
        pc_write = 1'b0;
        freeze   = 1'b1;
        halted   = 1'b1;
      end
      S_RUN: ;
      default: begin
        pc_write    = 1'b0;
        freeze      = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    endcase

    if (run_mode) begin
      if (bus.mem_busy) begin
        pc_write = 1'b0;
        freeze   = 1'b1;
      end else if (bus.redir_valid) begin
        sel          = bus.redir_sel;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        redirect_now = 1'b1;
      end else if (bus.halt_req) begin
        pc_write    = 1'b0;
        flush_if_id = 1'b1;
      end else if (bus.ld_use_stall) begin
        pc_write    = 1'b0;
        freeze      = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  assign bus.pc_update_mux_signal = sel;
  assign bus.pc_write             = pc_write;
  assign bus.freeze               = freeze;
  assign bus.flush_if_id          = flush_if_id;
  assign bus.flush_id_ex          = flush_id_ex;
  assign bus.halted               = halted;

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] perf_reg [2];
  logic [1:0]       perf_inc;

  assign perf_inc[0] = !pc_write && (state_reg == S_RUN || state_reg == S_MEMWAIT);
  assign perf_inc[1] = redirect_now;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      always_ff @(posedge clk) begin
        if (rst) begin
          perf_reg[gi] <= '0;
        end else if (perf_inc[gi] && perf_reg[gi] != {CNT_W{1'b1}}) begin
          perf_reg[gi] <= perf_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cnt = perf_reg[0];
  assign flush_cnt = perf_reg[1];
`else
  logic unused_redirect;
  assign unused_redirect = redirect_now;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios followed by random
// stimulus against a countdown-based behavioural model.
module tb_if_fetch_ctrl;
  localparam int BOOT_CYCLES  = 1;
  localparam int DRAIN_CYCLES = 3;
`ifdef IF_PERF_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 16;
`endif
  localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

  localparam int P_BOOT = 0, P_RUN = 1, P_WAIT = 2, P_DRAIN = 3, P_HALT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  if_fetch_ctrl_if bus();
`ifdef IF_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  if_fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(TB_CNT_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef IF_PERF_CNT_EN
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state: phase, countdown of remaining boot/drain cycles, buffered redirect
  int         ph = P_BOOT;
  int         left = 0;
  logic [1:0] pq[$];
  bit         known = 1'b0;
  int         n_ph, n_left;
  logic [1:0] n_pq[$];
  logic [6:0] e;            // {sel[1:0], pc_write, freeze, flush_if_id, flush_id_ex, halted}
  logic [6:0] obs;
  bit         fired, stall_ev;
  int         m_stall = 0, m_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic model_eval(input bit rv, input logic [1:0] rs, input bit lu, input bit mb,
                            input bit hr);
    logic [1:0] s;
    bit pcw, frz, fi, fe, h, runlike;
    s = 2'b00; pcw = 1; frz = 0; fi = 0; fe = 0; h = 0; runlike = 0;
    fired = 0;
    n_ph = ph; n_left = left; n_pq = pq;
    case (ph)
      P_BOOT: begin
        pcw = 0; frz = 1; fi = 1; fe = 1;
        if (left == 1) n_ph = P_RUN; else n_left = left - 1;
      end
      P_RUN: runlike = 1;
      P_WAIT: begin
        if (mb) begin
          pcw = 0; frz = 1;
          if (rv && pq.size() == 0) n_pq.push_back(rs);
        end else if (pq.size() != 0) begin
          s = pq[0]; fi = 1; fe = 1; fired = 1;
          n_pq.delete(); n_ph = P_RUN;
        end else runlike = 1;
      end
      P_DRAIN: begin
        pcw = 0; fi = 1;
        if (rv) begin
          s = rs; pcw = 1; fe = 1; fired = 1; n_ph = P_RUN;
        end else if (mb) frz = 1;
        else if (left == 1) n_ph = P_HALT;
        else n_left = left - 1;
      end
      default: begin pcw = 0; frz = 1; h = 1; end
    endcase
    if (runlike) begin
      if (mb) begin
        pcw = 0; frz = 1; n_ph = P_WAIT;
        if (rv) n_pq.push_back(rs);
      end else if (rv) begin
        s = rs; fi = 1; fe = 1; fired = 1; n_ph = P_RUN;
      end else if (hr) begin
        pcw = 0; fi = 1; n_ph = P_DRAIN; n_left = DRAIN_CYCLES;
      end else if (lu) begin
        pcw = 0; frz = 1; fe = 1;
      end
    end
    stall_ev = !pcw && (ph == P_RUN || ph == P_WAIT);
    e = {s, pcw, frz, fi, fe, h};
  endtask

  task automatic commit(input bit r);
    if (r) begin
      ph = P_BOOT; left = BOOT_CYCLES; pq.delete(); known = 1'b1;
      m_stall = 0; m_flush = 0;
    end else if (known) begin
      ph = n_ph; left = n_left; pq = n_pq;
      if (stall_ev && m_stall < CNT_MAX) m_stall++;
      if (fired && m_flush < CNT_MAX) m_flush++;
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [1:0] rs, input bit lu,
                      input bit mb, input bit hr);
    rst = r;
    bus.redir_valid = rv; bus.redir_sel = rs; bus.ld_use_stall = lu;
    bus.mem_busy = mb; bus.halt_req = hr;
    #3;
    model_eval(rv, rs, lu, mb, hr);
    obs = {bus.pc_update_mux_signal, bus.pc_write, bus.freeze, bus.flush_if_id,
           bus.flush_id_ex, bus.halted};
    if (known) begin
      check("outs", 32'(obs), 32'(e));
`ifdef IF_PERF_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
    end
    @(posedge clk);
    commit(r);
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 2'b00, 0, 0, 0);
  endtask

  int halt_age = 0;

  initial begin
    bus.redir_valid = 0; bus.redir_sel = 2'b00; bus.ld_use_stall = 0;
    bus.mem_busy = 0; bus.halt_req = 0;
    #1;
    // reset and boot
    step(1, 0, 2'b00, 0, 0, 0);
    step(1, 0, 2'b00, 0, 0, 0);
    idle();
    check("boot_out", 32'({obs[4], obs[2], obs[1]}), 32'(3'b011));
    idle();
    check("run_seq", 32'({obs[6:5], obs[4]}), 32'(3'b001));

    // redirect beats a same-cycle load-use stall
    step(0, 1, 2'b10, 1, 0, 0);
    check("redir_vs_lu", 32'(obs), 32'(7'b10_1_0_1_1_0));

    // redirect buffered across a 3-cycle memory stall
    step(0, 1, 2'b01, 0, 1, 0);
    check("mw_pcw1", 32'(obs[4]), 32'd0);
    step(0, 0, 2'b00, 0, 1, 0);
    check("mw_pcw2", 32'(obs[4]), 32'd0);
    step(0, 1, 2'b11, 0, 1, 0);
    check("mw_pcw3", 32'(obs[4]), 32'd0);
    idle();
    check("mw_replay", 32'(obs), 32'(7'b01_1_0_1_1_0));

    // halt drain then sticky halted
    step(0, 0, 2'b00, 0, 0, 1);
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      idle();
      check("drain", 32'({obs[2], obs[0]}), 32'(2'b10));
    end
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], 2'(i), 1, i[1], 1);
      check("halted", 32'({obs[4], obs[0]}), 32'(2'b01));
    end

    // redirect in the second drain cycle cancels the halt
    step(1, 0, 2'b00, 0, 0, 0);
    idle();
    step(0, 0, 2'b00, 0, 0, 1);
    idle();
    step(0, 1, 2'b11, 0, 0, 0);
    check("drain_cancel", 32'(obs[6:4]), 32'(3'b111));
    for (int i = 0; i < 5; i++) begin
      idle();
      check("no_halt", 32'(obs[0]), 32'd0);
    end

    // reset during MEMWAIT drops the buffered redirect
    step(0, 1, 2'b10, 0, 1, 0);
    step(1, 0, 2'b00, 0, 1, 0);
    idle();
    idle();
    check("rst_pend", 32'({obs[6:5], obs[4]}), 32'(3'b001));

`ifdef IF_PERF_CNT_EN
    for (int i = 0; i < 20; i++) step(0, 0, 2'b00, 1, 0, 0);
    check("stall_sat", 32'(stall_cnt), 32'd15);
    step(1, 0, 2'b00, 0, 0, 0);
    check("stall_rst", 32'(stall_cnt), 32'd0);
    idle();
`endif

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0) || (ph == P_HALT && halt_age > 6);
      step(r, $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 24) == 0);
      halt_age = (ph == P_HALT) ? halt_age + 1 : 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
